sobol_seq_gen: RTL and testbench

Single-dimension Sobol low-discrepancy generator feeding `inverseCDF_step1`. It produces a run of `num_samples` uniform values u ∈ (0,1) in signed fixed point Q(QINT.QFRAC) over a valid/ready handshake. It uses Gray-code XOR recursion against a per-dimension direction-number table. It sits at the head of the QMC normal-variate chain; one instance runs per path dimension.

---
 rtl/fpga_cfg_pkg.sv | 6 +
 rtl/sobol_seq_gen_pkg.sv | 24 ++
 rtl/sobol_lowest_zero.sv | 14 +
 rtl/sobol_seq_gen.sv | 118 +++++++++++
 tb/tb_sobol_seq_gen.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// Project-wide fixed-point format shared by the QMC normal-variate chain.
package fpga_cfg_pkg;
  localparam int FP_WIDTH = 16;
  localparam int FP_QINT  = 4;
  localparam int FP_QFRAC = 12;
endpackage

// File: rtl/sobol_seq_gen_pkg.sv
// Sobol direction numbers (Joe-Kuo, left-aligned to SOBOL_QFRAC bits) and FSM state type.
package sobol_seq_gen_pkg;
  localparam int SOBOL_NUM_DIMS = 2;
  localparam int SOBOL_QFRAC    = fpga_cfg_pkg::FP_QFRAC;

  typedef logic [SOBOL_QFRAC-1:0] sobol_dir_t;
  typedef logic [SOBOL_NUM_DIMS-1:0][SOBOL_QFRAC-1:0][SOBOL_QFRAC-1:0] sobol_tab_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sobol_state_t;

  // Dim 0 is van der Corput; dim 1 (primitive poly x+1) obeys v[k] = v[k-1] ^ (v[k-1] >> 1).
  function automatic sobol_tab_t sobol_build();
    sobol_tab_t t;
    t = '0;
    for (int k = 0; k < SOBOL_QFRAC; k++)
      t[0][k] = sobol_dir_t'(1) << (SOBOL_QFRAC - 1 - k);
    t[1][0] = sobol_dir_t'(1) << (SOBOL_QFRAC - 1);
    for (int k = 1; k < SOBOL_QFRAC; k++)
      t[1][k] = t[1][k-1] ^ (t[1][k-1] >> 1);
    return t;
  endfunction

  localparam sobol_tab_t SOBOL_V = sobol_build();
endpackage

// File: rtl/sobol_lowest_zero.sv
// Priority encoder: index of the lowest zero bit of n_i (0 when n_i is all ones).
module sobol_lowest_zero #(
  parameter int QFRAC = 12,
  parameter int CW    = 4
) (
  input  logic [QFRAC-1:0] n_i,
  output logic [CW-1:0]    c_o
);
  always_comb begin
    c_o = '0;
    for (int i = QFRAC - 1; i >= 0; i--)
      if (!n_i[i]) c_o = CW'(i);
  end
endmodule

// File: rtl/sobol_seq_gen.sv
// Single-dimension Sobol generator, Gray-code recursion, valid/ready output.
// Optional digital shift under `define SOBOL_SHIFT_EN. QFRAC must match SOBOL_QFRAC.
module sobol_seq_gen
  import sobol_seq_gen_pkg::*;
#(
  parameter int WIDTH = fpga_cfg_pkg::FP_WIDTH,
  parameter int QINT  = fpga_cfg_pkg::FP_QINT,
  parameter int QFRAC = fpga_cfg_pkg::FP_QFRAC,
  parameter int DIM   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             num_samples,
  input  logic [QFRAC-1:0]        shift_seed,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] u,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);
  localparam int CW = (QFRAC > 1) ? $clog2(QFRAC) : 1;
  localparam logic [QFRAC-1:0] NMAX = '1;

  sobol_state_t      state_q, state_d;
  logic [QFRAC-1:0]  n_q, n_d, x_q, x_d, x_next, frac;
  logic [31:0]       rem_q, rem_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, advance;
  logic [WIDTH-1:0]  u_q, u_d;
  logic [CW-1:0]     c;

  sobol_lowest_zero #(.QFRAC(QFRAC), .CW(CW)) u_lz (.n_i(n_q), .c_o(c));

  assign x_next = x_q ^ SOBOL_V[DIM][c];

`ifdef SOBOL_SHIFT_EN
  logic [QFRAC-1:0] seed_q, seed_d;
  assign seed_d = (state_q == S_IDLE && start) ? shift_seed : seed_q;
  always_ff @(posedge clk) begin
    if (rst) seed_q <= '0;
    else     seed_q <= seed_d;
  end
  // A shifted zero would leave (0,1); nudge it to one LSB.
  always_comb begin
    frac = x_next ^ seed_q;
    if (frac == '0) frac = {{(QFRAC-1){1'b0}}, 1'b1};
  end
`else
  logic unused_seed;
  assign unused_seed = ^shift_seed;
  assign frac        = x_next;
`endif

  assign advance = (state_q == S_RUN) && (!valid_q || ready_in) &&
                   (rem_q != '0) && (n_q != NMAX);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    x_d     = x_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    u_d     = u_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: if (start) begin
        rem_d   = num_samples;
        n_d     = '0;
        x_d     = '0;
        ovf_d   = 1'b0;
        state_d = (num_samples == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (rem_q != '0 && n_q == NMAX) begin
          ovf_d = 1'b1;
          rem_d = '0;
        end else if (advance) begin
          x_d     = x_next;
          n_d     = n_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          u_d     = {{QINT{1'b0}}, frac};
          valid_d = 1'b1;
        end
        if (!advance && valid_q && ready_in) valid_d = 1'b0;
        if (rem_q == '0 && (!valid_q || ready_in)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      u_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      u_q     <= u_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_out = valid_q;
  assign u         = u_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_sobol_seq_gen.sv
// Directed bench for sobol_seq_gen at Q4.12, DIM 0 (van der Corput).
module tb_sobol_seq_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_samples = '0;
  logic [11:0] shift_seed = '0;
  logic        ready_in = 1'b1;
  logic        valid_out, busy, done, overflow;
  logic [15:0] u;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] q_samp[$];
  int   done_cyc, done_cnt, first_vld, last_hs, stall_viol;
  logic ovf_at_done, busy_after;

  sobol_seq_gen #(.WIDTH(16), .QINT(4), .QFRAC(12), .DIM(0)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .shift_seed(shift_seed), .ready_in(ready_in), .valid_out(valid_out),
    .u(u), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: ready follows 1,0,0,1 repeating.
  task automatic run(input int n, input int mode, input logic [11:0] seed, input int budget);
    logic rdy, prev_stall;
    logic [15:0] prev_u;
    q_samp.delete();
    done_cyc = -1; done_cnt = 0; first_vld = -1; last_hs = -1; stall_viol = 0;
    ovf_at_done = 1'b0; busy_after = 1'b1;
    prev_stall = 1'b0; prev_u = '0;
    @(negedge clk);
    start = 1'b1; num_samples = n; shift_seed = seed;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
      ready_in = rdy;
      if (prev_stall && (!valid_out || u != prev_u)) stall_viol++;
      if (valid_out && first_vld < 0) first_vld = cyc;
      if (valid_out && rdy) begin q_samp.push_back(u); last_hs = cyc; end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; ovf_at_done = overflow; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after = busy; break; end
      prev_stall = valid_out && !rdy;
      prev_u = u;
      @(negedge clk);
    end
    ready_in = 1'b1;
    if (done_cyc < 0) chk("timeout", 32'd1, 32'd0);
  endtask

  logic [15:0] exp5 [5];
  logic        seen [4096];
  int          dups, zeros, hibits;

  initial begin
    exp5[0] = 16'h0800; exp5[1] = 16'h0C00; exp5[2] = 16'h0400;
    exp5[3] = 16'h0600; exp5[4] = 16'h0E00;

    repeat (3) @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_u", u, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // N=5, ready high
    run(5, 0, 12'h000, 50);
    chk("n5_count", q_samp.size(), 5);
    for (int i = 0; i < 5 && i < q_samp.size(); i++) chk($sformatf("n5_u%0d", i), q_samp[i], exp5[i]);
    chk("n5_first_vld", first_vld, 2);
    chk("n5_done_cyc", done_cyc, 7);
    chk("n5_done_cnt", done_cnt, 1);
    chk("n5_ovf", ovf_at_done, 0);
    chk("n5_busy_after", busy_after, 0);

    // N=5 with stalls
    run(5, 1, 12'h000, 80);
    chk("stall_count", q_samp.size(), 5);
    for (int i = 0; i < 5 && i < q_samp.size(); i++) chk($sformatf("stall_u%0d", i), q_samp[i], exp5[i]);
    chk("stall_stable", stall_viol, 0);
    chk("stall_done_after", done_cyc > last_hs, 1);
    chk("stall_done_cnt", done_cnt, 1);

    // N=0
    run(0, 0, 12'h000, 20);
    chk("n0_count", q_samp.size(), 0);
    chk("n0_vld", first_vld, -1);
    chk("n0_done_cyc", done_cyc, 1);
    chk("n0_done_cnt", done_cnt, 1);

    // Exhaustion
    run(4096 + 3, 0, 12'h000, 5000);
    chk("exh_count", q_samp.size(), 4095);
    foreach (seen[i]) seen[i] = 1'b0;
    dups = 0; zeros = 0; hibits = 0;
    foreach (q_samp[i]) begin
      if (q_samp[i][15:12] != 4'h0) hibits++;
      if (q_samp[i][11:0] == 12'h000) zeros++;
      if (seen[q_samp[i][11:0]]) dups++;
      seen[q_samp[i][11:0]] = 1'b1;
    end
    chk("exh_dups", dups, 0);
    chk("exh_zeros", zeros, 0);
    chk("exh_hibits", hibits, 0);
    chk("exh_ovf", ovf_at_done, 1);
    chk("exh_done_cnt", done_cnt, 1);

    // Reset mid-run
    @(negedge clk);
    start = 1'b1; num_samples = 10; shift_seed = '0;
    @(negedge clk);
    start = 1'b0; ready_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid_pre", valid_out, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid", valid_out, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    rst = 1'b0; ready_in = 1'b1;
    done_cnt = 0;
    repeat (4) begin @(negedge clk); if (done) done_cnt++; end
    chk("mid_no_done", done_cnt, 0);
    run(1, 0, 12'h000, 20);
    chk("restart_count", q_samp.size(), 1);
    if (q_samp.size() > 0) chk("restart_u", q_samp[0], 16'h0800);

`ifdef SOBOL_SHIFT_EN
    run(3, 0, 12'h800, 30);
    chk("shift_count", q_samp.size(), 3);
    if (q_samp.size() == 3) begin
      chk("shift_u0", q_samp[0], 16'h0001);
      chk("shift_u1", q_samp[1], 16'h0400);
      chk("shift_u2", q_samp[2], 16'h0C00);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
